// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. Produces the write
//   enables and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   from three events: load-use hazards in ID, taken branches resolved in MEM,
//   and multi-cycle data-memory accesses (req/ready handshake with timeout).
//   Keeps saturating stall-cycle and flush-event counters.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   ID_rs, ID_rt, ID_uses_rt    source operands of the ID instruction
//   EX_memread, EX_writereg     load in EX and its destination
//   MEM_memread, MEM_memwrite   memory access in MEM
//   MEM_branch, MEM_zero        branch resolution in MEM
//   dmem_ready / dmem_req       data-memory handshake
//   PC_write .. MEMWB_bubble    pipeline register controls (combinational)
//   mem_error                   sticky timeout flag
//   stall_count, flush_count    saturating performance counters
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             EX_memread,
   input  logic [4:0]       EX_writereg,
   input  logic             MEM_memread,
   input  logic             MEM_memwrite,
   input  logic             MEM_branch,
   input  logic             MEM_zero,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             PC_write,
   output logic             PC_src,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_write,
   output logic             IDEX_bubble,
   output logic             EXMEM_write,
   output logic             EXMEM_flush,
   output logic             MEMWB_bubble,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

   localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       macc, freeze, br_taken, load_use, timeout_hit;

   assign macc = MEM_memread | MEM_memwrite;

   // Freeze covers a fresh miss in RUN, an unfinished wait, and ERROR.
   // A ready in MEM_WAIT releases the pipeline in that same cycle.
   assign freeze = (state == ERROR) |
                   (~dmem_ready & ((state == RUN & macc) | (state == MEM_WAIT)));

   assign br_taken = MEM_branch & MEM_zero & ~freeze;

   assign load_use = EX_memread & (EX_writereg != 5'd0) &
                     ((EX_writereg == ID_rs) | (ID_uses_rt & (EX_writereg == ID_rt)));

   assign timeout_hit = (state == MEM_WAIT) & ~dmem_ready & (wait_cnt == TIMEOUT);

   // State register, wait counter, sticky error and perf counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_error   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == RUN && macc && !dmem_ready)
            wait_cnt <= 8'd1;
         else if (state == MEM_WAIT && !dmem_ready && !timeout_hit)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout_hit)
            mem_error <= 1'b1;
         if (!PC_write && stall_count != CNT_MAX)
            stall_count <= stall_count + 1'b1;
         if (br_taken && flush_count != CNT_MAX)
            flush_count <= flush_count + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (macc && !dmem_ready) state_nxt = MEM_WAIT;
         MEM_WAIT: if (dmem_ready)          state_nxt = RUN;
                   else if (timeout_hit)    state_nxt = ERROR;
         ERROR:    state_nxt = ERROR;
         default:  state_nxt = RUN;
      endcase
   end

   // Control outputs; priority freeze > branch flush > load-use
   always_comb begin
      dmem_req     = ~rst & macc & (state != ERROR);
      PC_write     = 1'b1;
      PC_src       = 1'b0;
      IFID_write   = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_write   = 1'b1;
      IDEX_bubble  = 1'b0;
      EXMEM_write  = 1'b1;
      EXMEM_flush  = 1'b0;
      MEMWB_bubble = 1'b0;
      if (rst) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         IFID_flush   = 1'b1;
         IDEX_bubble  = 1'b1;
         EXMEM_flush  = 1'b1;
         MEMWB_bubble = 1'b1;
      end else if (freeze) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         MEMWB_bubble = 1'b1;
      end else if (br_taken) begin
         PC_src      = 1'b1;
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
         EXMEM_flush = 1'b1;
      end else if (load_use) begin
         // ID/EX keeps loading so the bubble actually enters EX
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_rs, ID_rt, EX_writereg;
   logic       ID_uses_rt, EX_memread, MEM_memread, MEM_memwrite;
   logic       MEM_branch, MEM_zero, dmem_ready;

   // instance 0: default parameters; instance 1: short timeout, 4-bit counters
   logic        req0, pcw0, pcs0, ifw0, iff0, idw0, idb0, exw0, exf0, wbb0, err0;
   logic        req1, pcw1, pcs1, ifw1, iff1, idw1, idb1, exw1, exf1, wbb1, err1;
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u0 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_memread(EX_memread), .EX_writereg(EX_writereg), .MEM_memread(MEM_memread),
      .MEM_memwrite(MEM_memwrite), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
      .dmem_ready(dmem_ready), .dmem_req(req0), .PC_write(pcw0), .PC_src(pcs0),
      .IFID_write(ifw0), .IFID_flush(iff0), .IDEX_write(idw0), .IDEX_bubble(idb0),
      .EXMEM_write(exw0), .EXMEM_flush(exf0), .MEMWB_bubble(wbb0), .mem_error(err0),
      .stall_count(sc0), .flush_count(fc0));

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_memread(EX_memread), .EX_writereg(EX_writereg), .MEM_memread(MEM_memread),
      .MEM_memwrite(MEM_memwrite), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
      .dmem_ready(dmem_ready), .dmem_req(req1), .PC_write(pcw1), .PC_src(pcs1),
      .IFID_write(ifw1), .IFID_flush(iff1), .IDEX_write(idw1), .IDEX_bubble(idb1),
      .EXMEM_write(exw1), .EXMEM_flush(exf1), .MEMWB_bubble(wbb1), .mem_error(err1),
      .stall_count(sc1), .flush_count(fc1));

   // observed bundles: {req,PC_write,PC_src,IFID_w,IFID_f,IDEX_w,IDEX_b,EXMEM_w,EXMEM_f,MEMWB_b,err}
   logic [10:0] ctl [2];
   int          stl [2];
   int          fl  [2];
   assign ctl[0] = {req0, pcw0, pcs0, ifw0, iff0, idw0, idb0, exw0, exf0, wbb0, err0};
   assign ctl[1] = {req1, pcw1, pcs1, ifw1, iff1, idw1, idb1, exw1, exf1, wbb1, err1};
   assign stl[0] = int'(sc0);
   assign stl[1] = int'(sc1);
   assign fl[0]  = int'(fc0);
   assign fl[1]  = int'(fc1);

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode 0 run, 1 waiting, 2 dead; waited = MEM_WAIT cycles spent
   int          tmo [2] = '{16, 4};
   int          cmax[2] = '{65535, 15};
   int          mode[2], waited[2], m_stall[2], m_flush[2];
   bit          m_err[2];
   logic [10:0] e_ctl[2];
   int          e_stall[2], e_flush[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0; waited[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_err[i] = 0;
      end
   end

   // Drive one cycle of inputs, compute expected outputs, advance the model.
   task automatic apply(input bit r, input bit mrd, input bit mwr, input bit br, input bit z,
                        input bit rdy, input bit exm, input bit [4:0] ewr,
                        input bit [4:0] rs, input bit [4:0] rt, input bit urt);
      bit acc, hz, stop, take, req;
      @(negedge clk);
      rst = r; MEM_memread = mrd; MEM_memwrite = mwr; MEM_branch = br; MEM_zero = z;
      dmem_ready = rdy; EX_memread = exm; EX_writereg = ewr; ID_rs = rs; ID_rt = rt;
      ID_uses_rt = urt;
      #1;
      acc = mrd | mwr;
      hz  = exm && ewr != 0 && (ewr == rs || (urt && ewr == rt));
      for (int i = 0; i < 2; i++) begin
         stop = (mode[i] == 2) || (!rdy && ((mode[i] == 0 && acc) || mode[i] == 1));
         take = br && z && !stop;
         req  = acc && mode[i] != 2;
         e_stall[i] = m_stall[i];
         e_flush[i] = m_flush[i];
         if (r)         e_ctl[i] = {1'b0, 9'b0_0_0_1_0_1_0_1_1, m_err[i]};
         else if (stop) e_ctl[i] = {req, 9'b0_0_0_0_0_0_0_0_1, m_err[i]};
         else if (take) e_ctl[i] = {req, 9'b1_1_1_1_1_1_1_1_0, m_err[i]};
         else if (hz)   e_ctl[i] = {req, 9'b0_0_0_0_1_1_1_0_0, m_err[i]};
         else           e_ctl[i] = {req, 9'b1_0_1_0_1_0_1_0_0, m_err[i]};
         if (r) begin
            mode[i] = 0; waited[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_err[i] = 0;
         end else begin
            if (!e_ctl[i][9]) m_stall[i] = (m_stall[i] < cmax[i]) ? m_stall[i] + 1 : cmax[i];
            if (take)         m_flush[i] = (m_flush[i] < cmax[i]) ? m_flush[i] + 1 : cmax[i];
            if (mode[i] == 0 && acc && !rdy) begin
               mode[i] = 1; waited[i] = 0;
            end else if (mode[i] == 1) begin
               if (rdy) mode[i] = 0;
               else begin
                  waited[i]++;
                  if (waited[i] >= tmo[i]) begin mode[i] = 2; m_err[i] = 1; end
               end
            end
         end
      end
   endtask

   task automatic idle(input bit r);
      apply(r, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   task automatic test_reset;
      idle(1);
      idle(1);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (ctl[i] !== 11'b0_0_0_0_1_0_1_0_1_1_0) begin
            n_fail++;
            $display("FAIL reset_outputs inst%0d got %b want %b", i, ctl[i], 11'b00001010110);
         end
      end
      idle(0);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (ctl[i] !== 11'b0_1_0_1_0_1_0_1_0_0_0 || stl[i] !== 0 || fl[i] !== 0) begin
            n_fail++;
            $display("FAIL reset_idle inst%0d ctl %b want 01010101000 stall %0d flush %0d", i, ctl[i], stl[i], fl[i]);
         end
      end
   endtask

   task automatic test_load_use;
      idle(1);
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: apply(0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);  // rs match
            1: apply(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);  // $zero never stalls
            2: apply(0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0);  // rt not a source
            default: apply(0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 1);  // rt match
         endcase
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ctl[i] !== e_ctl[i] || stl[i] !== e_stall[i] || fl[i] !== e_flush[i]) begin
               n_fail++;
               $display("FAIL load_use c%0d inst%0d ctl %b want %b stall %0d want %0d", c, i, ctl[i], e_ctl[i], stl[i], e_stall[i]);
            end
         end
      end
      idle(0);
      n_tests++;
      if (sc0 !== 16'd2) begin
         n_fail++;
         $display("FAIL load_use_count got %0d want 2", sc0);
      end
   endtask

   task automatic test_branch;
      idle(1);
      apply(0, 0, 0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0);  // taken branch with hazard present
      n_tests++;
      if (pcs0 !== 1'b1 || pcw0 !== 1'b1 || iff0 !== 1'b1 || idb0 !== 1'b1 || exf0 !== 1'b1 || ifw0 !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_taken ctl %b want 01111111100", ctl[0]);
      end
      apply(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);  // not taken
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (ctl[i] !== e_ctl[i] || fl[i] !== 1 || stl[i] !== 0) begin
            n_fail++;
            $display("FAIL branch_not_taken inst%0d ctl %b want %b flush %0d want 1 stall %0d want 0", i, ctl[i], e_ctl[i], fl[i], stl[i]);
         end
      end
   endtask

   task automatic test_mem_wait;
      int reqs, frz;
      reqs = 0; frz = 0;
      idle(1);
      for (int c = 0; c < 4; c++) begin
         apply(0, 1, 0, 0, 0, c == 3, 0, 5'd0, 5'd0, 5'd0, 0);
         reqs += int'(req0);
         frz  += int'(!pcw0 && wbb0 && !exw0);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ctl[i] !== e_ctl[i]) begin
               n_fail++;
               $display("FAIL mem_wait c%0d inst%0d ctl %b want %b", c, i, ctl[i], e_ctl[i]);
            end
         end
      end
      n_tests++;
      if (reqs != 4 || frz != 3 || ctl[0] !== 11'b1_1_0_1_0_1_0_1_0_0_0) begin
         n_fail++;
         $display("FAIL mem_wait_shape req %0d want 4 freeze %0d want 3 last %b", reqs, frz, ctl[0]);
      end
      idle(0);
      n_tests++;
      if (sc0 !== 16'd3 || pcw0 !== 1'b1) begin
         n_fail++;
         $display("FAIL mem_wait_release stall %0d want 3 pcw %b want 1", sc0, pcw0);
      end
   endtask

   task automatic test_timeout;
      idle(1);
      for (int c = 0; c < 5; c++) begin
         apply(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
         n_tests++;
         if (err1 !== 1'b0 || req1 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early c%0d err %b want 0 req %b want 1", c, err1, req1);
         end
      end
      apply(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      n_tests++;
      if (err1 !== 1'b1 || req1 !== 1'b0 || err0 !== 1'b0 || req0 !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_hit err1 %b req1 %b want 1,0; err0 %b req0 %b want 0,1", err1, req1, err0, req0);
      end
      apply(0, 0, 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (ctl[i] !== e_ctl[i] || stl[i] !== e_stall[i] || fl[i] !== e_flush[i]) begin
            n_fail++;
            $display("FAIL timeout_ready inst%0d ctl %b want %b stall %0d want %0d", i, ctl[i], e_ctl[i], stl[i], e_stall[i]);
         end
      end
      n_tests++;
      if (pcw1 !== 1'b0 || wbb1 !== 1'b1 || pcs1 !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_persist pcw %b wbb %b pcs %b want 0 1 0", pcw1, wbb1, pcs1);
      end
      idle(1);
      idle(0);
      n_tests++;
      if (err1 !== 1'b0 || pcw1 !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_clear err %b pcw %b want 0 1", err1, pcw1);
      end
   endtask

   task automatic test_saturation;
      idle(1);
      for (int c = 0; c < 20; c++) apply(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      idle(0);
      n_tests++;
      if (sc1 !== 4'd15 || sc0 !== 16'd20) begin
         n_fail++;
         $display("FAIL saturation stall1 %0d want 15 stall0 %0d want 20", sc1, sc0);
      end
   endtask

   task automatic test_random;
      int bad;
      bad = 0;
      idle(1);
      for (int c = 0; c < 600; c++) begin
         apply($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ctl[i] !== e_ctl[i] || stl[i] !== e_stall[i] || fl[i] !== e_flush[i]) begin
               n_fail++;
               bad++;
               if (bad < 10)
                  $display("FAIL random c%0d inst%0d ctl %b want %b stall %0d want %0d flush %0d want %0d",
                           c, i, ctl[i], e_ctl[i], stl[i], e_stall[i], fl[i], e_flush[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; EX_memread = 0; EX_writereg = 0;
      MEM_memread = 0; MEM_memwrite = 0; MEM_branch = 0; MEM_zero = 0; dmem_ready = 0;
      test_reset;
      test_load_use;
      test_branch;
      test_mem_wait;
      test_timeout;
      test_saturation;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
